mc_ctrl_fsm: RTL and testbench

- Multi-cycle MIPS control unit: the driving end of the PC, IR and status-register write interfaces.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Generates the PC and IR write enables, datapath mux selects, ALU op class, and memory/register-file strobes.
- Stalls on memory accesses via a ready handshake and consumes the combinational ALU zero flag for branches.

---
 rtl/mc_ctrl_fsm_if.sv | 38 +++
 rtl/mc_ctrl_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// The master drives the control strobes and the slave returns opcode, ALU zero and memory ready.
interface mc_ctrl_fsm_if;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  logic [OPCODE_W-1:0] opcode;
  logic                alu_zero;
  logic                mem_ready;

  logic                pc_we;
  logic                ir_we;
  logic [1:0]          pc_src;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                iord;
  logic                mem_rd;
  logic                mem_we;
  logic                reg_we;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                instr_done;
  logic                illegal;
  logic [STATE_W-1:0]  state;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output pc_we, ir_we, pc_src, alu_src_a, alu_src_b, alu_op, iord,
           mem_rd, mem_we, reg_we, reg_dst, mem_to_reg, instr_done, illegal, state
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  pc_we, ir_we, pc_src, alu_src_a, alu_src_b, alu_op, iord,
           mem_rd, mem_we, reg_we, reg_dst, mem_to_reg, instr_done, illegal, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: steps each instruction through fetch, decode,
// execute, memory and writeback, stalling on memory ready.
module mc_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic          clock,
  input  logic          rst,
  mc_ctrl_fsm_if.master bus
);
  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4,
    S_MEM_WR = 4'd5,
    S_R_EXEC = 4'd6,
    S_R_WB   = 4'd7,
    S_BRANCH = 4'd8,
    S_I_EXEC = 4'd9,
    S_I_WB   = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  state_e              state_q, state_d;
  logic                illegal_q, illegal_d;
  logic                br_ne_q, br_ne_d;

  logic [OPCODE_W-1:0] opcode;
  logic                alu_zero;
  logic                mem_ready;

  logic       pc_we_c, ir_we_c, alu_src_a_c, iord_c, mem_rd_c, mem_we_c;
  logic       reg_we_c, reg_dst_c, mem_to_reg_c, instr_done_c, illegal_c;
  logic [1:0] pc_src_c, alu_src_b_c, alu_op_c;

  assign opcode    = bus.opcode;
  assign alu_zero  = bus.alu_zero;
  assign mem_ready = bus.mem_ready;

  // State, sticky illegal flag and branch polarity captured in DECODE
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= state_e'(RESET_STATE);
      illegal_q <= 1'b0;
      br_ne_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      br_ne_q   <= br_ne_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    br_ne_d      = br_ne_q;
    pc_we_c      = 1'b0;
    ir_we_c      = 1'b0;
    pc_src_c     = 2'd0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'd0;
    alu_op_c     = 2'd0;
    iord_c       = 1'b0;
    mem_rd_c     = 1'b0;
    mem_we_c     = 1'b0;
    reg_we_c     = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = illegal_q;

    case (state_q)
      S_FETCH: begin
        mem_rd_c    = 1'b1;
        alu_src_b_c = 2'd1;
        pc_we_c     = mem_ready;
        ir_we_c     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'd3;
        br_ne_d     = (opcode == OP_BNE);
        case (opcode)
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_LW, OP_SW:   state_d = S_ADDR;
          OP_ADDI:        state_d = S_I_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default: begin
            state_d      = S_FETCH;
            illegal_d    = 1'b1;
            instr_done_c = 1'b1;
          end
        endcase
      end
      S_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FETCH;
      end
      S_MEM_RD: begin
        mem_rd_c = 1'b1;
        iord_c   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we_c     = 1'b1;
        mem_to_reg_c = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_we_c     = 1'b1;
        iord_c       = 1'b1;
        instr_done_c = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'd2;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_we_c     = 1'b1;
        reg_dst_c    = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c  = 1'b1;
        alu_op_c     = 2'd1;
        pc_src_c     = 2'd1;
        pc_we_c      = br_ne_q ? ~alu_zero : alu_zero;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        reg_we_c     = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_src_c     = 2'd2;
        pc_we_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks every strobe regardless of the state decode
    if (rst) begin
      pc_we_c      = 1'b0;
      ir_we_c      = 1'b0;
      pc_src_c     = 2'd0;
      alu_src_a_c  = 1'b0;
      alu_src_b_c  = 2'd0;
      alu_op_c     = 2'd0;
      iord_c       = 1'b0;
      mem_rd_c     = 1'b0;
      mem_we_c     = 1'b0;
      reg_we_c     = 1'b0;
      reg_dst_c    = 1'b0;
      mem_to_reg_c = 1'b0;
      instr_done_c = 1'b0;
      illegal_c    = 1'b0;
    end
  end

  assign bus.pc_we      = pc_we_c;
  assign bus.ir_we      = ir_we_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.iord       = iord_c;
  assign bus.mem_rd     = mem_rd_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.reg_we     = reg_we_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.mem_to_reg = mem_to_reg_c;
  assign bus.instr_done = instr_done_c;
  assign bus.illegal    = illegal_c;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected control vectors for each
// instruction class, memory stalls, mid-instruction reset and illegal opcodes.
module tb_mc_ctrl_fsm;
  logic clock;
  logic rst;
  int   tests;
  int   failed;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {state, pc_we, ir_we, pc_src, alu_src_a, alu_src_b, alu_op, iord, mem_rd, mem_we, reg_we, reg_dst, mem_to_reg, instr_done, illegal}
  logic [20:0] obs;
  assign obs = {bus.state, bus.pc_we, bus.ir_we, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.iord, bus.mem_rd, bus.mem_we, bus.reg_we, bus.reg_dst,
                bus.mem_to_reg, bus.instr_done, bus.illegal};

  function automatic logic [20:0] v(input logic [3:0] st, input logic pcwe, input logic irwe,
                                    input logic [1:0] pcsrc, input logic a, input logic [1:0] b,
                                    input logic [1:0] op, input logic iord, input logic rd,
                                    input logic we, input logic rwe, input logic rdst,
                                    input logic m2r, input logic done, input logic ill);
    return {st, pcwe, irwe, pcsrc, a, b, op, iord, rd, we, rwe, rdst, m2r, done, ill};
  endfunction

  localparam logic Z = 1'b0;
  localparam logic O = 1'b1;

  function automatic logic [20:0] e_fetch(input logic r, input logic ill);
    return v(4'd0, r, r, 2'd0, Z, 2'd1, 2'd0, Z, O, Z, Z, Z, Z, Z, ill);
  endfunction
  function automatic logic [20:0] e_decode(input logic d, input logic ill);
    return v(4'd1, Z, Z, 2'd0, Z, 2'd3, 2'd0, Z, Z, Z, Z, Z, Z, d, ill);
  endfunction
  function automatic logic [20:0] e_addr(input logic ill);
    return v(4'd2, Z, Z, 2'd0, O, 2'd2, 2'd0, Z, Z, Z, Z, Z, Z, Z, ill);
  endfunction
  function automatic logic [20:0] e_memrd(input logic ill);
    return v(4'd3, Z, Z, 2'd0, Z, 2'd0, 2'd0, O, O, Z, Z, Z, Z, Z, ill);
  endfunction
  function automatic logic [20:0] e_memwb(input logic ill);
    return v(4'd4, Z, Z, 2'd0, Z, 2'd0, 2'd0, Z, Z, Z, O, Z, O, O, ill);
  endfunction
  function automatic logic [20:0] e_memwr(input logic r, input logic ill);
    return v(4'd5, Z, Z, 2'd0, Z, 2'd0, 2'd0, O, Z, O, Z, Z, Z, r, ill);
  endfunction
  function automatic logic [20:0] e_rexec(input logic ill);
    return v(4'd6, Z, Z, 2'd0, O, 2'd0, 2'd2, Z, Z, Z, Z, Z, Z, Z, ill);
  endfunction
  function automatic logic [20:0] e_rwb(input logic ill);
    return v(4'd7, Z, Z, 2'd0, Z, 2'd0, 2'd0, Z, Z, Z, O, O, Z, O, ill);
  endfunction
  function automatic logic [20:0] e_branch(input logic p, input logic ill);
    return v(4'd8, p, Z, 2'd1, O, 2'd0, 2'd1, Z, Z, Z, Z, Z, Z, O, ill);
  endfunction
  function automatic logic [20:0] e_iexec(input logic ill);
    return v(4'd9, Z, Z, 2'd0, O, 2'd2, 2'd0, Z, Z, Z, Z, Z, Z, Z, ill);
  endfunction
  function automatic logic [20:0] e_iwb(input logic ill);
    return v(4'd10, Z, Z, 2'd0, Z, 2'd0, 2'd0, Z, Z, Z, O, Z, Z, O, ill);
  endfunction
  function automatic logic [20:0] e_jump(input logic ill);
    return v(4'd11, O, Z, 2'd2, Z, 2'd0, 2'd0, Z, Z, Z, Z, Z, Z, O, ill);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.opcode = 6'h00;
    bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clock);
    tests++;
    if (obs !== 21'd0) begin
      failed++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 21'd0);
    end
    @(posedge clock); #1;
    rst = 1'b0;
  endtask

  task automatic test_rtype(input logic ill);
    logic [20:0] ex [4];
    ex = '{e_fetch(O, ill), e_decode(Z, ill), e_rexec(ill), e_rwb(ill)};
    bus.opcode = 6'h00;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      tests++;
      if (obs !== ex[i]) begin
        failed++;
        $display("FAIL rtype cyc%0d got=%h exp=%h", i, obs, ex[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_lw_stall();
    logic [20:0] ex [10];
    logic        rdy [10];
    int          irw;
    ex  = '{e_fetch(Z, Z), e_fetch(Z, Z), e_fetch(O, Z), e_decode(Z, Z), e_addr(Z),
            e_memrd(Z), e_memrd(Z), e_memrd(Z), e_memrd(Z), e_memwb(Z)};
    rdy = '{Z, Z, O, O, O, Z, Z, Z, O, O};
    irw = 0;
    bus.opcode = 6'h23;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = rdy[i];
      @(negedge clock);
      if (bus.ir_we === 1'b1) irw++;
      tests++;
      if (obs !== ex[i]) begin
        failed++;
        $display("FAIL lw_stall cyc%0d got=%h exp=%h", i, obs, ex[i]);
      end
      @(posedge clock); #1;
    end
    tests++;
    if (irw !== 1) begin
      failed++;
      $display("FAIL lw_ir_we_count got=%0d exp=1", irw);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [4];
    logic       zs  [4];
    logic       pw  [4];
    logic [20:0] ex [3];
    ops = '{6'h04, 6'h04, 6'h05, 6'h05};
    zs  = '{O, Z, O, Z};
    pw  = '{O, Z, Z, O};
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.opcode = ops[k];
      bus.alu_zero = zs[k];
      ex = '{e_fetch(O, Z), e_decode(Z, Z), e_branch(pw[k], Z)};
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        tests++;
        if (obs !== ex[i]) begin
          failed++;
          $display("FAIL branch op=%h z=%0b cyc%0d got=%h exp=%h", ops[k], zs[k], i, obs, ex[i]);
        end
        @(posedge clock); #1;
      end
    end
    bus.alu_zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [20:0] ex [3];
    ex = '{e_fetch(O, Z), e_decode(Z, Z), e_jump(Z)};
    bus.opcode = 6'h02;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests++;
      if (obs !== ex[i]) begin
        failed++;
        $display("FAIL jump cyc%0d got=%h exp=%h", i, obs, ex[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_addi();
    logic [20:0] ex [4];
    ex = '{e_fetch(O, Z), e_decode(Z, Z), e_iexec(Z), e_iwb(Z)};
    bus.opcode = 6'h08;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      tests++;
      if (obs !== ex[i]) begin
        failed++;
        $display("FAIL addi cyc%0d got=%h exp=%h", i, obs, ex[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_sw_reset_mid();
    logic [20:0] ex [4];
    logic [20:0] ex2 [5];
    logic        rdy [4];
    logic        rdy2 [5];
    ex   = '{e_fetch(O, Z), e_decode(Z, Z), e_addr(Z), e_memwr(Z, Z)};
    rdy  = '{O, O, O, Z};
    ex2  = '{e_fetch(Z, Z), e_fetch(O, Z), e_decode(Z, Z), e_addr(Z), e_memwr(O, Z)};
    rdy2 = '{Z, O, O, O, O};
    bus.opcode = 6'h2B;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = rdy[i];
      @(negedge clock);
      tests++;
      if (obs !== ex[i]) begin
        failed++;
        $display("FAIL sw_pre cyc%0d got=%h exp=%h", i, obs, ex[i]);
      end
      @(posedge clock); #1;
    end
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    tests++;
    if (obs !== 21'd0) begin
      failed++;
      $display("FAIL sw_reset_mid got=%h exp=%h", obs, 21'd0);
    end
    @(posedge clock); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rdy2[i];
      @(negedge clock);
      tests++;
      if (obs !== ex2[i]) begin
        failed++;
        $display("FAIL sw_post cyc%0d got=%h exp=%h", i, obs, ex2[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_illegal(input logic ill_before);
    logic [20:0] ex [2];
    ex = '{e_fetch(O, ill_before), e_decode(O, ill_before)};
    bus.opcode = 6'h3F;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests++;
      if (obs !== ex[i]) begin
        failed++;
        $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs, ex[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_clears_illegal();
    bus.opcode = 6'h00;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (obs !== 21'd0) begin
      failed++;
      $display("FAIL reset_clear got=%h exp=%h", obs, 21'd0);
    end
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    tests++;
    if (obs !== e_fetch(Z, Z)) begin
      failed++;
      $display("FAIL reset_clear_fetch got=%h exp=%h", obs, e_fetch(Z, Z));
    end
    @(posedge clock); #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_rtype(1'b0);
    test_lw_stall();
    test_branch();
    test_jump();
    test_addi();
    test_sw_reset_mid();
    test_illegal(1'b0);
    test_rtype(1'b1);
    test_illegal(1'b1);
    test_reset_clears_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
